// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path and the peripheral decoder
// that maps it into the CPU data-memory space.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } rx_state_e;

  localparam int OVS_RATE  = 16;
  localparam int OVS_MID   = 7;
  localparam int DATA_BITS = 8;

  localparam logic [3:0] OVS_LAST_C = 4'(OVS_RATE - 1);
  localparam logic [3:0] OVS_MID_C  = 4'(OVS_MID);
  localparam logic [2:0] BIT_LAST_C = 3'(DATA_BITS - 1);

  // Byte offsets of the UART registers inside the peripheral window
  localparam logic [7:0] UART_RX_DATA_OFS = 8'h00;
  localparam logic [7:0] UART_RX_STAT_OFS = 8'h04;
  localparam logic [7:0] UART_CTRL_OFS    = 8'h08;

  localparam int STAT_RX_VALID_BIT  = 0;
  localparam int STAT_OVERRUN_BIT   = 1;
  localparam int STAT_FRAME_ERR_BIT = 2;

  function automatic logic [7:0] pack_rx_status(input logic valid,
                                                input logic ovr,
                                                input logic ferr);
    logic [7:0] v;
    v = 8'h00;
    v[STAT_RX_VALID_BIT]  = valid;
    v[STAT_OVERRUN_BIT]   = ovr;
    v[STAT_FRAME_ERR_BIT] = ferr;
    return v;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks
// (the 16x oversample strobe for the receiver).
`timescale 1ns/1ps
module baud_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = (r_count == LAST_C);
  assign tick   = w_wrap;

  // Divider counter, wraps to zero on the tick cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with 16x oversampling, one-byte holding register,
// sticky overrun/frame-error flags and a level interrupt.
`timescale 1ns/1ps
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  input  logic       irq_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       irq
);

  localparam int DIV = CLK_HZ / (BAUD * OVS_RATE);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  logic                 w_tick;
  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [3:0]           r_ovs;
  logic [3:0]           w_ovs_nxt;
  logic [2:0]           r_bit;
  logic [2:0]           w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_stop_ok;
  logic                 w_stop_bad;
  logic                 r_load_pend;
  logic [7:0]           r_rx_data;
  logic                 r_rx_valid;
  logic                 r_overrun;
  logic                 r_frame_err;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_rx_s = r_sync2;

  // Synchronizer and receive FSM state; sync flops reset high so a
  // reset mid-frame re-arms in IDLE without a break wait
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= ST_IDLE;
      r_ovs   <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= '0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_ovs   <= w_ovs_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic; the FSM only moves on oversample ticks
  always_comb begin
    w_state_nxt = r_state;
    w_ovs_nxt   = r_ovs;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = ST_START;
            w_ovs_nxt   = 4'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_START: begin
          if (r_ovs == OVS_MID_C) begin
            if (!w_rx_s) begin
              w_state_nxt = ST_DATA;
              w_ovs_nxt   = 4'd0;
              w_bit_nxt   = 3'd0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_ovs_nxt = r_ovs + 4'd1;
          end
        end
        ST_DATA: begin
          if (r_ovs == OVS_LAST_C) begin
            w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
            w_ovs_nxt   = 4'd0;
            if (r_bit == BIT_LAST_C) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_bit_nxt = r_bit + 3'd1;
            end
          end else begin
            w_ovs_nxt = r_ovs + 4'd1;
          end
        end
        ST_STOP: begin
          if (r_ovs == OVS_LAST_C) begin
            w_ovs_nxt = 4'd0;
            if (w_rx_s) begin
              w_stop_ok   = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_stop_bad  = 1'b1;
              w_state_nxt = ST_BRK;
            end
          end else begin
            w_ovs_nxt = r_ovs + 4'd1;
          end
        end
        ST_BRK: begin
          // A held-low line must go idle before another start is accepted
          if (w_rx_s) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_BRK;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Holding register and sticky flags; a load coinciding with a read
  // replaces the byte instead of flagging overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_pend <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_load_pend <= w_stop_ok;
      if (r_load_pend && (!r_rx_valid || rd_en)) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (rd_en) begin
        r_rx_valid <= 1'b0;
      end
      if (r_load_pend && r_rx_valid && !rd_en) begin
        r_overrun <= 1'b1;
      end else if (clr_err) begin
        r_overrun <= 1'b0;
      end
      if (w_stop_bad) begin
        r_frame_err <= 1'b1;
      end else if (clr_err) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign irq       = r_rx_valid & irq_en;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at DIV=1 (16 clocks per bit); every
// expected value is hand-computed from the frame being driven.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic       irq_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       irq;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .irq_en    (irq_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .irq       (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    step(n);
  endtask

  // Start bit, 8 data bits LSB first, then the given stop level (left on the line)
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
    drive_bit(stop_bit, 16);
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d99;
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0; irq_en = 1'b1;
    step(3);
    check_eq("rst_data", rx_data, 8'h00);
    check_eq("rst_valid", rx_valid, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_irq", irq, 1'b0);
    rst = 1'b0;
    step(4);

    // 1: basic frame and latency from the falling edge
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        int k;
        k = 0;
        while (!rx_valid && k < 200) begin
          step(1);
          k++;
        end
        lat = k;
      end
    join
    check_eq($sformatf("t1_latency_%0d_in_155_157", lat), (lat >= 155 && lat <= 157), 1'b1);
    step(4);
    check_eq("t1_data", rx_data, 8'hA5);
    check_eq("t1_valid", rx_valid, 1'b1);
    check_eq("t1_overrun", overrun, 1'b0);
    check_eq("t1_frame_err", frame_err, 1'b0);
    check_eq("t1_irq_en1", irq, 1'b1);
    irq_en = 1'b0;
    #1;
    check_eq("t1_irq_en0", irq, 1'b0);
    irq_en = 1'b1;
    pulse_rd();
    check_eq("t1_rd_valid", rx_valid, 1'b0);
    check_eq("t1_rd_data_kept", rx_data, 8'hA5);

    // 2: short glitch rejected, then a good frame
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    check_eq("t2_glitch_valid", rx_valid, 1'b0);
    send_frame(8'h3C, 1'b1);
    step(4);
    check_eq("t2_data", rx_data, 8'h3C);
    check_eq("t2_valid", rx_valid, 1'b1);
    pulse_rd();

    // 3: overrun keeps the first byte
    send_frame(8'h11, 1'b1);
    step(4);
    send_frame(8'h22, 1'b1);
    step(4);
    check_eq("t3_data", rx_data, 8'h11);
    check_eq("t3_overrun", overrun, 1'b1);
    check_eq("t3_valid", rx_valid, 1'b1);
    pulse_rd();
    check_eq("t3_rd_valid", rx_valid, 1'b0);
    check_eq("t3_rd_data", rx_data, 8'h11);
    pulse_clr();
    check_eq("t3_clr_overrun", overrun, 1'b0);

    // 4: bad stop bit, held-low line, then recovery
    send_frame(8'h55, 1'b0);
    drive_bit(1'b0, 40);
    check_eq("t4_frame_err", frame_err, 1'b1);
    check_eq("t4_valid", rx_valid, 1'b0);
    drive_bit(1'b1, 40);
    check_eq("t4_no_spurious", rx_valid, 1'b0);
    send_frame(8'h0F, 1'b1);
    step(4);
    check_eq("t4_next_data", rx_data, 8'h0F);
    check_eq("t4_next_valid", rx_valid, 1'b1);
    check_eq("t4_ferr_sticky", frame_err, 1'b1);
    pulse_clr();
    check_eq("t4_clr_ferr", frame_err, 1'b0);
    pulse_rd();

    // 5: read on the exact load cycle replaces the held byte
    send_frame(8'h66, 1'b1);
    step(4);
    check_eq("t5_hold_data", rx_data, 8'h66);
    fork
      send_frame(8'h77, 1'b1);
      begin
        step(155);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
      end
    join
    step(4);
    check_eq("t5_data", rx_data, 8'h77);
    check_eq("t5_valid", rx_valid, 1'b1);
    check_eq("t5_overrun", overrun, 1'b0);

    // 6: reset during the last data bit of 0x99 abandons the frame
    d99 = 8'h99;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 7; i++) drive_bit(d99[i], 16);
    drive_bit(d99[7], 8);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("t6_rst_data", rx_data, 8'h00);
    check_eq("t6_rst_valid", rx_valid, 1'b0);
    check_eq("t6_rst_overrun", overrun, 1'b0);
    check_eq("t6_rst_frame_err", frame_err, 1'b0);
    check_eq("t6_rst_irq", irq, 1'b0);
    drive_bit(d99[7], 8);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 20);
    check_eq("t6_partial_dropped", rx_valid, 1'b0);
    send_frame(8'hC3, 1'b1);
    step(4);
    check_eq("t6_data", rx_data, 8'hC3);
    check_eq("t6_valid", rx_valid, 1'b1);
    check_eq("t6_frame_err", frame_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
